// File: rtl/param_combo_lock.sv
// rtl/param_combo_lock.sv - parametrised serial combination lock with timed open and lockout
// Fixed-length framed attempts against a reprogrammable code; repeated failures force a timed lockout.
module param_combo_lock #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] CODE           = 5'b01011,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  OPEN_CYCLES    = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              valid,
  input  logic                              in,
  input  logic                              clear,
  input  logic                              relock,
  input  logic                              code_wr,
  input  logic [CODE_LEN-1:0]               code_in,
  output logic                              unlock,
  output logic                              is_open,
  output logic                              locked_out,
  output logic [$clog2(CODE_LEN+1)-1:0]     digits,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int DW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {ENTRY, OPEN, LOCKOUT} state_t;

  state_t              state, state_n;
  logic [CODE_LEN-2:0] sh, sh_n;
  logic [CODE_LEN-1:0] code_reg, code_n;
  logic [CODE_LEN-1:0] attempt;
  logic [DW-1:0]       digits_n;
  logic [FW-1:0]       fail_n;
  logic [TW-1:0]       timer, timer_n;
  logic                final_digit;
  logic                match;

  // The final digit is compared straight from the input, so only CODE_LEN-1 digits are stored.
  assign attempt     = {sh, in};
  assign final_digit = (digits == DW'(CODE_LEN - 1));
  assign match       = (attempt == code_reg);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ENTRY;
      sh         <= '0;
      code_reg   <= CODE;
      digits     <= '0;
      fail_cnt   <= '0;
      timer      <= '0;
      is_open    <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      code_reg   <= code_n;
      digits     <= digits_n;
      fail_cnt   <= fail_n;
      timer      <= timer_n;
      is_open    <= (state_n == OPEN);
      locked_out <= (state_n == LOCKOUT);
    end
  end

  always_comb begin
    state_n  = state;
    sh_n     = sh;
    code_n   = code_reg;
    digits_n = digits;
    fail_n   = fail_cnt;
    timer_n  = timer;
    unlock   = 1'b0;
    case (state)
      ENTRY: begin
        // clear outranks a simultaneous digit press
        if (clear) begin
          digits_n = '0;
        end else if (valid) begin
          if (!final_digit) begin
            sh_n     = attempt[CODE_LEN-2:0];
            digits_n = digits + 1'b1;
          end else begin
            digits_n = '0;
            if (match) begin
              unlock  = 1'b1;
              state_n = OPEN;
              timer_n = TW'(OPEN_CYCLES - 1);
              fail_n  = '0;
            end else if (fail_cnt == FW'(MAX_FAIL - 1)) begin
              state_n = LOCKOUT;
              timer_n = TW'(LOCKOUT_CYCLES - 1);
              fail_n  = FW'(MAX_FAIL);
            end else begin
              fail_n = fail_cnt + 1'b1;
            end
          end
        end
      end
      OPEN: begin
        if (code_wr) code_n = code_in;
        if (relock || timer == '0) begin
          state_n = ENTRY;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          state_n = ENTRY;
          fail_n  = '0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = ENTRY;
    endcase
  end

endmodule

// File: tb/tb_param_combo_lock.sv
// tb/tb_param_combo_lock.sv - directed plus randomized check of param_combo_lock
// Reference model tracks entered digits as a queue and open/lockout time as remaining-cycle counts.
module tb_param_combo_lock;

  localparam int CL = 5;
  localparam int MF = 3;
  localparam int LC = 16;
  localparam int OC = 32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        valid = 1'b0, in = 1'b0, clear = 1'b0, relock = 1'b0, code_wr = 1'b0;
  logic [4:0]  code_in = '0;
  logic        unlock, is_open, locked_out;
  logic [2:0]  digits;
  logic [1:0]  fail_cnt;

  int checks = 0;
  int failures = 0;
  int open_count = 0;
  int lock_count = 0;

  int      m_open, m_lock, m_fail;
  bit [4:0] m_code;
  bit      m_q[$];

  param_combo_lock #(
    .CODE_LEN(CL), .CODE(5'b01011), .MAX_FAIL(MF),
    .LOCKOUT_CYCLES(LC), .OPEN_CYCLES(OC)
  ) dut (
    .CLK(CLK), .RST(RST), .valid(valid), .in(in), .clear(clear),
    .relock(relock), .code_wr(code_wr), .code_in(code_in),
    .unlock(unlock), .is_open(is_open), .locked_out(locked_out),
    .digits(digits), .fail_cnt(fail_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_open = 0;
    m_lock = 0;
    m_fail = 0;
    m_code = 5'b01011;
    m_q.delete();
  endfunction

  function automatic bit m_step(bit v, bit i, bit c, bit rl, bit cw, bit [4:0] ci);
    bit u = 1'b0;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fail = 0;
    end else if (m_open > 0) begin
      if (cw) m_code = ci;
      if (rl) m_open = 0;
      else    m_open--;
    end else if (c) begin
      m_q.delete();
    end else if (v) begin
      m_q.push_back(i);
      if (m_q.size() == CL) begin
        int val = 0;
        foreach (m_q[k]) val = val * 2 + int'(m_q[k]);
        if (val == int'(m_code)) begin
          u = 1'b1;
          m_open = OC;
          m_fail = 0;
        end else begin
          m_fail++;
          if (m_fail == MF) m_lock = LC;
        end
        m_q.delete();
      end
    end
    return u;
  endfunction

  task automatic check_regs();
    chk("is_open", is_open, m_open > 0);
    chk("locked_out", locked_out, m_lock > 0);
    chk("digits", digits, m_q.size());
    chk("fail_cnt", fail_cnt, m_fail);
    if (is_open) open_count++;
    if (locked_out) lock_count++;
  endtask

  task automatic step(input bit v, input bit i, input bit c, input bit rl, input bit cw, input bit [4:0] ci);
    bit eu;
    @(negedge CLK);
    check_regs();
    valid = v; in = i; clear = c; relock = rl; code_wr = cw; code_in = ci;
    #1;
    eu = m_step(v, i, c, rl, cw, ci);
    chk("unlock", unlock, eu);
  endtask

  task automatic press(input bit b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0, 5'b0);
  endtask

  task automatic press_code(input bit [4:0] c);
    for (int k = 4; k >= 0; k--) press(c[k]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    valid = 0; in = 0; clear = 0; relock = 0; code_wr = 0; code_in = '0;
    RST = 1'b1;
    #1;
    chk("rst_unlock", unlock, 0);
    chk("rst_is_open", is_open, 0);
    chk("rst_locked_out", locked_out, 0);
    chk("rst_digits", digits, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    m_reset();
    #2 RST = 1'b0;
  endtask

  initial begin
    m_reset();
    do_reset();

    // correct code opens for exactly OC cycles
    open_count = 0;
    press_code(5'b01011);
    idle(40);
    chk("open_len", open_count, OC);

    // three failures lock out; correct code ignored during lockout
    lock_count = 0;
    press_code(5'b11111);
    press_code(5'b11111);
    press_code(5'b11111);
    press_code(5'b01011);
    idle(15);
    chk("lock_len", lock_count, LC);
    press_code(5'b01011);
    idle(35);

    // clear abandons a partial entry
    press(0); press(1); press(0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b0);
    press_code(5'b01011);
    idle(35);

    // reprogram plus relock in the same cycle
    open_count = 0;
    press_code(5'b01011);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11100);
    idle(2);
    chk("relock_len", open_count, 4);
    press_code(5'b01011);
    press_code(5'b11100);
    idle(35);
    do_reset();
    press_code(5'b01011);
    idle(35);

    // reset mid-entry after two failures
    press_code(5'b11111);
    press_code(5'b11111);
    press(0); press(1); press(0);
    do_reset();
    press_code(5'b01011);
    idle(35);

    // clear with the final correct digit discards it
    press(0); press(1); press(0); press(1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b0);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      bit v, i, c, rl, cw;
      bit [4:0] ci;
      if ($urandom % 200 == 0) begin
        do_reset();
      end else begin
        v  = ($urandom % 3) != 0;
        i  = ($urandom % 2) ? m_code[CL-1-m_q.size()] : 1'($urandom % 2);
        c  = ($urandom % 16) == 0;
        rl = ($urandom % 16) == 0;
        cw = ($urandom % 8) == 0;
        ci = 5'($urandom);
        step(v, i, c, rl, cw, ci);
      end
    end

    @(negedge CLK);
    check_regs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_combo_lock.md
# param_combo_lock

Parametrised electronic combination lock: serial single-bit keypad entries are framed into fixed-length attempts and compared against a runtime-reprogrammable code. A correct code produces a Mealy unlock pulse and holds the lock open for a bounded time. Repeated failures force a timed lockout. It is the generalised successor to the fixed 5-digit 01011 lock and sits between the debounced keypad logic and the door actuator driver.

## Interface
- CODE_LEN, 5: digits per attempt (≥2)
- CODE, 5'b01011: reset/default code; first digit entered is MSB
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (≥1)
- LOCKOUT_CYCLES, 16: lockout duration in clocks (≥1)
- OPEN_CYCLES, 32: auto-relock timeout in clocks (≥1)
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- valid  in  1  one-cycle strobe: a digit is pressed this cycle
- in  in  1  digit value, sampled when valid=1
- clear  in  1  abandon partial entry (ENTRY state only)
- relock  in  1  close lock immediately (OPEN state only)
- code_wr  in  1  load code_in as new code (OPEN state only)
- code_in  in  CODE_LEN  new code value, MSB entered first
- unlock  out  1  combinational Mealy pulse on the correct final digit
- is_open  out  1  registered; high while in OPEN
- locked_out  out  1  registered; high while in LOCKOUT
- digits  out  $clog2(CODE_LEN+1)  digits entered in the current attempt
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed attempts

## Operation
- Internal regs: state {ENTRY, OPEN, LOCKOUT}; shift register sh[CODE_LEN-2:0]; code_reg[CODE_LEN-1:0]; digits; fail_cnt; timer of width $clog2(max(LOCKOUT_CYCLES,OPEN_CYCLES)+1).
- Reset: state=ENTRY, code_reg=CODE, sh=0, digits=0, fail_cnt=0, timer=0, is_open=0, locked_out=0. unlock=0 because state≠OPEN-transition and valid gating.
- ENTRY, clear=1: digits←0. Any valid in the same cycle is discarded. fail_cnt is unchanged.
- ENTRY, valid=1, digits<CODE_LEN-1: sh←{sh[CODE_LEN-3:0],in}; digits++.
- ENTRY, valid=1, digits==CODE_LEN-1 (final digit): compare {sh,in} with code_reg.
  - Match: unlock=1 combinationally this cycle. Next edge: state←OPEN, timer←OPEN_CYCLES-1, fail_cnt←0, digits←0.
  - Mismatch: digits←0. If fail_cnt==MAX_FAIL-1, then state←LOCKOUT, timer←LOCKOUT_CYCLES-1, fail_cnt←MAX_FAIL. Otherwise fail_cnt++.
- unlock = (state==ENTRY) & valid & ~clear & (digits==CODE_LEN-1) & ({sh,in}==code_reg).
- Attempts are framed and non-overlapping. A partial prefix is never reused across attempts.
- OPEN: valid and clear are ignored. code_wr=1 sets code_reg←code_in. relock=1 sets state←ENTRY at the next edge. Otherwise, timer==0 sets state←ENTRY; else timer--.
- OPEN, code_wr and relock in the same cycle: the write takes effect and the lock closes.
- code_wr outside OPEN is ignored; code_reg is unchanged.
- LOCKOUT: valid, clear, relock and code_wr are all ignored. timer==0 sets state←ENTRY and fail_cnt←0; else timer--.
- Leaving OPEN or LOCKOUT always re-enters ENTRY with digits=0.
- RST asserted mid-operation (any state, any timer value) returns everything to reset values immediately. code_reg reverts to CODE.

## Timing
- unlock: zero latency, same cycle as the final valid digit. It is never asserted in OPEN or LOCKOUT.
- is_open rises 1 edge after the unlock cycle. It stays high for exactly OPEN_CYCLES cycles unless relock shortens it. relock in the k-th open cycle means is_open falls at the following edge.
- locked_out rises 1 edge after the failing final digit and stays high for exactly LOCKOUT_CYCLES cycles.
- fail_cnt updates at the edge after a failing final digit.
- New code_reg is effective for the first attempt after OPEN exits.

## Test plan
- Reset, then press 0,1,0,1,1 -> unlock=1 only during the 5th press; is_open=1 for exactly 32 cycles, then 0; fail_cnt=0.
- Press 1,1,1,1,1 three times -> fail_cnt goes 1,2; after the 3rd attempt locked_out=1 for 16 cycles. A correct code entered during lockout gives no unlock. After lockout, fail_cnt=0 and 0,1,0,1,1 unlocks.
- Press 0,1,0 then clear, then 0,1,0,1,1 -> no failure counted; unlock on the final digit; digits returns to 0.
- Unlock, code_wr with code_in=5'b11100 plus relock in the same cycle -> closes next edge; 0,1,0,1,1 now fails; 1,1,1,0,0 unlocks. RST restores 01011.
- Fail twice, then RST mid-lockout-free entry at digits=3 -> all outputs 0. The next correct code unlocks; fail_cnt stays 0.
- valid and clear in the same cycle on the final digit of a correct code -> unlock=0, digits=0, fail_cnt unchanged.
